// File: rtl/dram_cache_pkg.sv
// Shared types and default sizes for the DRAM write-back cache.
// The optional flush engine is enabled by defining DRAM_WB_CACHE_FLUSH_EN,
// which adds the FLUSH state to the controller enum.
package dram_cache_pkg;

    // Default geometry: 8-bit word addresses, 64-bit words, 16 lines.
    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 64;
    localparam int CACHE_IDX_W = 4;
    localparam int CACHE_TAG_W = ADDR_W - CACHE_IDX_W;

    // Controller states.
    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB_REQ,
        WB_WAIT,
        FILL_REQ,
        FILL_WAIT,
        RESP
`ifdef DRAM_WB_CACHE_FLUSH_EN
        ,
        FLUSH
`endif
    } cache_state_e;

    // One cache line.
    // Its field widths come from the package sizes above, so a different
    // geometry is chosen by editing the package, not by overriding the
    // parameters on a single instance.
    typedef struct packed {
        logic                   valid;
        logic                   dirty;
        logic [CACHE_TAG_W-1:0] tag;
        logic [DATA_W-1:0]      data;
    } cache_line_t;

endpackage

// File: rtl/dram_wb_cache_array.sv
// Tag/data/valid/dirty storage for the direct-mapped cache.
// The module has one index.
// That index drives a combinational read port and a synchronous
// whole-line write port.
// Valid and dirty bits clear asynchronously on rst.
// Tag and data storage is never reset.
module dram_wb_cache_array #(
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic              wr_valid,
    input  logic              wr_dirty,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data
);
    import dram_cache_pkg::*;

    localparam int ENTRIES = 2 ** IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] dirty_q;
    logic [TAG_W-1:0]   tag_q  [ENTRIES];
    logic [DATA_W-1:0]  data_q [ENTRIES];

    // Combinational read of the addressed line.
    always_comb begin
        rd_valid = valid_q[idx];
        rd_dirty = dirty_q[idx];
        rd_tag   = tag_q[idx];
        rd_data  = data_q[idx];
    end

    // Line state bits; these are the only part of the array that is reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[idx] <= wr_valid;
            dirty_q[idx] <= wr_dirty;
        end
    end

    // Tag and data payload, written together with the state bits.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[idx]  <= wr_tag;
            data_q[idx] <= wr_data;
        end
    end

endmodule

// File: rtl/dram_wb_cache.sv
// Direct-mapped, write-back, write-allocate cache in front of the DRAM bridge.
// Each line holds one 64-bit word.
// The bridge command port is used only for fills and evictions, and at most
// one bridge command is in flight at a time.
// Defining DRAM_WB_CACHE_FLUSH_EN adds flush_req/flush_done.
// With the flush enabled, all dirty lines are written back in ascending
// index order.
module dram_wb_cache #(
    parameter int IDX_W  = dram_cache_pkg::CACHE_IDX_W,
    parameter int ADDR_W = dram_cache_pkg::ADDR_W,
    parameter int DATA_W = dram_cache_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
`ifdef DRAM_WB_CACHE_FLUSH_EN
    input  logic              flush_req,
    output logic              flush_done,
`endif
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              C_in_valid,
    output logic              C_r_wb,
    output logic [ADDR_W-1:0] C_addr,
    output logic [DATA_W-1:0] C_data_w,
    input  logic              C_out_valid,
    input  logic [DATA_W-1:0] C_data_r
);
    import dram_cache_pkg::*;

    localparam int TAG_W = ADDR_W - IDX_W;

    cache_state_e      state_q;
    cache_state_e      state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;
    logic              cmd_r_wb_d;
    logic [ADDR_W-1:0] cmd_addr_d;
    logic [DATA_W-1:0] cmd_data_d;
    logic              accept;
    logic              hit;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  arr_idx;
    logic              arr_wr_en;
    cache_line_t       cur_line;
    cache_line_t       new_line;
    logic              rd_valid;
    logic              rd_dirty;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;

    assign req_idx = addr_q[IDX_W-1:0];
    assign req_tag = addr_q[ADDR_W-1:IDX_W];

`ifdef DRAM_WB_CACHE_FLUSH_EN
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    logic             flushing_q;
    logic             flushing_d;
    logic [IDX_W-1:0] flush_idx_q;
    logic [IDX_W-1:0] flush_idx_d;
    logic             flush_done_q;
    logic             flush_done_d;

    assign arr_idx    = flushing_q ? flush_idx_q : req_idx;
    assign flush_done = flush_done_q;
    assign req_ready  = (state_q == IDLE) && !rst && !flush_req;
`else
    assign arr_idx    = req_idx;
    assign req_ready  = (state_q == IDLE) && !rst;
`endif

    assign accept     = req_valid && req_ready;
    assign cur_line   = {rd_valid, rd_dirty, rd_tag, rd_data};
    assign hit        = cur_line.valid && (cur_line.tag == req_tag);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_rdata  = rsp_valid ? rdata_q : '0;
    assign C_in_valid = (state_q == WB_REQ) || (state_q == FILL_REQ);

    dram_wb_cache_array #(
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .idx      (arr_idx),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (arr_wr_en),
        .wr_valid (new_line.valid),
        .wr_dirty (new_line.dirty),
        .wr_tag   (new_line.tag),
        .wr_data  (new_line.data)
    );

    // Next-state logic.
    // Also decides the line write and the command register loads.
    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        cmd_r_wb_d = C_r_wb;
        cmd_addr_d = C_addr;
        cmd_data_d = C_data_w;
        arr_wr_en  = 1'b0;
        new_line   = cur_line;
`ifdef DRAM_WB_CACHE_FLUSH_EN
        flushing_d   = flushing_q;
        flush_idx_d  = flush_idx_q;
        flush_done_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
`ifdef DRAM_WB_CACHE_FLUSH_EN
                if (flush_req) begin
                    state_d     = FLUSH;
                    flushing_d  = 1'b1;
                    flush_idx_d = '0;
                end else
`endif
                if (accept) begin
                    state_d = LOOKUP;
                    rdata_d = '0;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    if (wr_q) begin
                        arr_wr_en      = 1'b1;
                        new_line.data  = wdata_q;
                        new_line.dirty = 1'b1;
                    end else begin
                        rdata_d = cur_line.data;
                    end
                    state_d = RESP;
                end else if (cur_line.valid && cur_line.dirty) begin
                    cmd_r_wb_d = 1'b0;
                    cmd_addr_d = {cur_line.tag, req_idx};
                    cmd_data_d = cur_line.data;
                    state_d    = WB_REQ;
                end else if (wr_q) begin
                    arr_wr_en      = 1'b1;
                    new_line.valid = 1'b1;
                    new_line.dirty = 1'b1;
                    new_line.tag   = req_tag;
                    new_line.data  = wdata_q;
                    state_d        = RESP;
                end else begin
                    cmd_r_wb_d = 1'b1;
                    cmd_addr_d = addr_q;
                    state_d    = FILL_REQ;
                end
            end
            WB_REQ: begin
                state_d = WB_WAIT;
            end
            WB_WAIT: begin
                if (C_out_valid) begin
                    arr_wr_en      = 1'b1;
                    new_line.dirty = 1'b0;
`ifdef DRAM_WB_CACHE_FLUSH_EN
                    if (flushing_q) begin
                        if (flush_idx_q == LAST_IDX) begin
                            state_d      = IDLE;
                            flushing_d   = 1'b0;
                            flush_done_d = 1'b1;
                        end else begin
                            flush_idx_d = flush_idx_q + 1'b1;
                            state_d     = FLUSH;
                        end
                    end else
`endif
                    if (wr_q) begin
                        new_line.valid = 1'b1;
                        new_line.dirty = 1'b1;
                        new_line.tag   = req_tag;
                        new_line.data  = wdata_q;
                        state_d        = RESP;
                    end else begin
                        cmd_r_wb_d = 1'b1;
                        cmd_addr_d = addr_q;
                        state_d    = FILL_REQ;
                    end
                end
            end
            FILL_REQ: begin
                state_d = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (C_out_valid) begin
                    arr_wr_en      = 1'b1;
                    new_line.valid = 1'b1;
                    new_line.dirty = 1'b0;
                    new_line.tag   = req_tag;
                    new_line.data  = C_data_r;
                    rdata_d        = C_data_r;
                    state_d        = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
`ifdef DRAM_WB_CACHE_FLUSH_EN
            FLUSH: begin
                if (cur_line.valid && cur_line.dirty) begin
                    cmd_r_wb_d = 1'b0;
                    cmd_addr_d = {cur_line.tag, flush_idx_q};
                    cmd_data_d = cur_line.data;
                    state_d    = WB_REQ;
                end else if (flush_idx_q == LAST_IDX) begin
                    state_d      = IDLE;
                    flushing_d   = 1'b0;
                    flush_done_d = 1'b1;
                end else begin
                    flush_idx_d = flush_idx_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register, request latches, response data and held bridge command fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            C_r_wb   <= 1'b0;
            C_addr   <= '0;
            C_data_w <= '0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            C_r_wb   <= cmd_r_wb_d;
            C_addr   <= cmd_addr_d;
            C_data_w <= cmd_data_d;
            if (accept) begin
                addr_q  <= req_addr;
                wr_q    <= req_wr;
                wdata_q <= req_wdata;
            end
        end
    end

`ifdef DRAM_WB_CACHE_FLUSH_EN
    // Flush walk position and completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flushing_q   <= 1'b0;
            flush_idx_q  <= '0;
            flush_done_q <= 1'b0;
        end else begin
            flushing_q   <= flushing_d;
            flush_idx_q  <= flush_idx_d;
            flush_done_q <= flush_done_d;
        end
    end
`endif

endmodule

// File: tb/tb_dram_wb_cache.sv
// Directed testbench for dram_wb_cache.
// A simple bridge model logs every command and answers after a fixed delay.
// When DRAM_WB_CACHE_FLUSH_EN is defined, flush_req is tied low.
module tb_dram_wb_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        C_in_valid;
    logic        C_r_wb;
    logic [7:0]  C_addr;
    logic [63:0] C_data_w;
    logic        C_out_valid;
    logic [63:0] C_data_r;
`ifdef DRAM_WB_CACHE_FLUSH_EN
    logic        flush_req = 1'b0;
    logic        flush_done;
`endif

    int          checks = 0;
    int          failures = 0;
    int          overlap_errs = 0;
    logic [63:0] bridge_rdata = 64'h0;
    logic        log_rwb[$];
    logic [7:0]  log_addr[$];
    logic [63:0] log_data[$];

    dram_wb_cache dut (
        .clk         (clk),
        .rst         (rst),
`ifdef DRAM_WB_CACHE_FLUSH_EN
        .flush_req   (flush_req),
        .flush_done  (flush_done),
`endif
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .C_in_valid  (C_in_valid),
        .C_r_wb      (C_r_wb),
        .C_addr      (C_addr),
        .C_data_w    (C_data_w),
        .C_out_valid (C_out_valid),
        .C_data_r    (C_data_r)
    );

    always #5 clk = ~clk;

    // Bridge model: logs commands on the falling edge and completes them three cycles later.
    initial begin : bridge
        int   cnt;
        logic busy;
        logic pend_rd;
        cnt = 0;
        busy = 1'b0;
        pend_rd = 1'b0;
        C_out_valid = 1'b0;
        C_data_r = 64'h0;
        forever begin
            @(negedge clk);
            C_out_valid = 1'b0;
            if (rst === 1'b1) begin
                busy = 1'b0;
                cnt = 0;
            end else if (busy) begin
                if (C_in_valid === 1'b1) overlap_errs++;
                cnt--;
                if (cnt == 0) begin
                    C_out_valid = 1'b1;
                    C_data_r = pend_rd ? bridge_rdata : 64'h0;
                    busy = 1'b0;
                end
            end else if (C_in_valid === 1'b1) begin
                log_rwb.push_back(C_r_wb);
                log_addr.push_back(C_addr);
                log_data.push_back(C_data_w);
                pend_rd = C_r_wb;
                busy = 1'b1;
                cnt = 3;
            end
        end
    end

    // Hard stop in case a wait somewhere never returns.
    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_log;
        log_rwb.delete();
        log_addr.delete();
        log_data.delete();
    endtask

    // Issues one request starting on a falling edge.
    // Returns on the falling edge where rsp_valid is seen.
    // lat counts clock edges from acceptance to the response.
    // waits counts the cycles spent waiting for req_ready.
    task automatic do_req(input logic wr, input logic [7:0] addr, input logic [63:0] wdata,
                          output logic [63:0] rdata, output int lat, output int waits);
        req_valid = 1'b1;
        req_wr = wr;
        req_addr = addr;
        req_wdata = wdata;
        waits = 0;
        while (req_ready !== 1'b1 && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_wr = 1'b0;
        req_addr = 8'h0;
        req_wdata = 64'h0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (rsp_valid !== 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL rsp_timeout addr=%h: rsp_valid=%b after %0d cycles, required 1", addr, rsp_valid, lat);
        end
        rdata = rsp_rdata;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 1'b0;
        req_wr = 1'b0;
        req_addr = 8'h0;
        req_wdata = 64'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_rdata, C_in_valid, C_r_wb, C_addr, C_data_w} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got ready=%b rsp=%b rdata=%h in=%b rwb=%b addr=%h wdata=%h, required all 0",
                     req_ready, rsp_valid, rsp_rdata, C_in_valid, C_r_wb, C_addr, C_data_w);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ready_after_reset: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_fill;
        logic [63:0] rd;
        int lat, waits;
        clear_log();
        bridge_rdata = 64'hDEAD_BEEF_0000_0001;
        do_req(1'b0, 8'h25, 64'h0, rd, lat, waits);
        checks++;
        if (log_addr.size() != 1) begin
            failures++;
            $display("[TB] FAIL fill_cmd_count: got %0d, required 1", log_addr.size());
        end else begin
            checks++;
            if (log_rwb[0] !== 1'b1 || log_addr[0] !== 8'h25) begin
                failures++;
                $display("[TB] FAIL fill_cmd: got rwb=%b addr=%h, required rwb=1 addr=25", log_rwb[0], log_addr[0]);
            end
        end
        checks++;
        if (rd !== 64'hDEAD_BEEF_0000_0001) begin
            failures++;
            $display("[TB] FAIL fill_rdata: got %h, required deadbeef00000001", rd);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 64'h0) begin
            failures++;
            $display("[TB] FAIL rsp_pulse: got valid=%b rdata=%h, required 0 and 0", rsp_valid, rsp_rdata);
        end
        checks++;
        if (C_r_wb !== 1'b1 || C_addr !== 8'h25) begin
            failures++;
            $display("[TB] FAIL cmd_hold: got rwb=%b addr=%h, required 1 and 25", C_r_wb, C_addr);
        end
    endtask

    task automatic test_hit;
        logic [63:0] rd;
        int lat, waits;
        clear_log();
        do_req(1'b0, 8'h25, 64'h0, rd, lat, waits);
        checks++;
        if (log_addr.size() != 0) begin
            failures++;
            $display("[TB] FAIL hit_no_cmd: got %0d commands, required 0", log_addr.size());
        end
        checks++;
        if (lat != 2) begin
            failures++;
            $display("[TB] FAIL hit_latency: got %0d, required 2", lat);
        end
        checks++;
        if (rd !== 64'hDEAD_BEEF_0000_0001) begin
            failures++;
            $display("[TB] FAIL hit_rdata: got %h, required deadbeef00000001", rd);
        end
        @(negedge clk);
    endtask

    task automatic test_store_evict;
        logic [63:0] rd;
        int lat, waits;
        clear_log();
        do_req(1'b1, 8'h13, 64'h11, rd, lat, waits);
        checks++;
        if (log_addr.size() != 0) begin
            failures++;
            $display("[TB] FAIL store_alloc_no_cmd: got %0d commands, required 0", log_addr.size());
        end
        @(negedge clk);
        do_req(1'b1, 8'h23, 64'h22, rd, lat, waits);
        checks++;
        if (log_addr.size() != 1) begin
            failures++;
            $display("[TB] FAIL evict_cmd_count: got %0d, required 1", log_addr.size());
        end else begin
            checks++;
            if (log_rwb[0] !== 1'b0 || log_addr[0] !== 8'h13 || log_data[0] !== 64'h11) begin
                failures++;
                $display("[TB] FAIL evict_cmd: got rwb=%b addr=%h data=%h, required 0 13 11",
                         log_rwb[0], log_addr[0], log_data[0]);
            end
        end
        @(negedge clk);
        checks++;
        if (C_r_wb !== 1'b0 || C_addr !== 8'h13 || C_data_w !== 64'h11) begin
            failures++;
            $display("[TB] FAIL wb_hold: got rwb=%b addr=%h data=%h, required 0 13 11", C_r_wb, C_addr, C_data_w);
        end
    endtask

    task automatic test_wb_then_fill;
        logic [63:0] rd;
        int lat, waits;
        clear_log();
        bridge_rdata = 64'h3333_0000_0000_0033;
        do_req(1'b0, 8'h33, 64'h0, rd, lat, waits);
        checks++;
        if (log_addr.size() != 2) begin
            failures++;
            $display("[TB] FAIL wb_fill_count: got %0d, required 2", log_addr.size());
        end else begin
            checks++;
            if (log_rwb[0] !== 1'b0 || log_addr[0] !== 8'h23 || log_data[0] !== 64'h22) begin
                failures++;
                $display("[TB] FAIL wb_first: got rwb=%b addr=%h data=%h, required 0 23 22",
                         log_rwb[0], log_addr[0], log_data[0]);
            end
            checks++;
            if (log_rwb[1] !== 1'b1 || log_addr[1] !== 8'h33) begin
                failures++;
                $display("[TB] FAIL fill_second: got rwb=%b addr=%h, required 1 33", log_rwb[1], log_addr[1]);
            end
        end
        checks++;
        if (rd !== 64'h3333_0000_0000_0033) begin
            failures++;
            $display("[TB] FAIL wb_fill_rdata: got %h, required 3333000000000033", rd);
        end
        @(negedge clk);
    endtask

    task automatic test_store_load;
        logic [63:0] rd;
        int lat, waits;
        clear_log();
        do_req(1'b1, 8'h40, 64'h5, rd, lat, waits);
        @(negedge clk);
        do_req(1'b0, 8'h40, 64'h0, rd, lat, waits);
        checks++;
        if (log_addr.size() != 0) begin
            failures++;
            $display("[TB] FAIL store_load_no_cmd: got %0d commands, required 0", log_addr.size());
        end
        checks++;
        if (rd !== 64'h5) begin
            failures++;
            $display("[TB] FAIL store_load_rdata: got %h, required 5", rd);
        end
        checks++;
        if (lat != 2) begin
            failures++;
            $display("[TB] FAIL store_load_latency: got %0d, required 2", lat);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [63:0] rd;
        int lat, waits;
        clear_log();
        do_req(1'b1, 8'h25, 64'h77, rd, lat, waits);
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ready_in_resp: got %b, required 0", req_ready);
        end
        do_req(1'b0, 8'h25, 64'h0, rd, lat, waits);
        checks++;
        if (waits != 1) begin
            failures++;
            $display("[TB] FAIL b2b_wait: got %0d cycles, required 1", waits);
        end
        checks++;
        if (rd !== 64'h77 || lat != 2) begin
            failures++;
            $display("[TB] FAIL b2b_rdata: got %h lat=%0d, required 77 lat=2", rd, lat);
        end
        checks++;
        if (log_addr.size() != 0) begin
            failures++;
            $display("[TB] FAIL b2b_no_cmd: got %0d commands, required 0", log_addr.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_fill;
        logic [63:0] rd;
        int lat, waits;
        clear_log();
        bridge_rdata = 64'h0000_0000_0000_5757;
        req_valid = 1'b1;
        req_wr = 1'b0;
        req_addr = 8'h57;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = 8'h0;
        @(negedge clk);
        checks++;
        if (C_in_valid !== 1'b1 || C_addr !== 8'h57) begin
            failures++;
            $display("[TB] FAIL fill_req_issue: got in=%b addr=%h, required 1 57", C_in_valid, C_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_rdata, C_in_valid, C_r_wb, C_addr, C_data_w} !== '0) begin
            failures++;
            $display("[TB] FAIL midfill_reset_outputs: got ready=%b rsp=%b rdata=%h in=%b rwb=%b addr=%h wdata=%h, required all 0",
                     req_ready, rsp_valid, rsp_rdata, C_in_valid, C_r_wb, C_addr, C_data_w);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_log();
        bridge_rdata = 64'h0123_4567_89AB_CDEF;
        do_req(1'b0, 8'h57, 64'h0, rd, lat, waits);
        checks++;
        if (log_addr.size() != 1) begin
            failures++;
            $display("[TB] FAIL refill_count: got %0d, required 1", log_addr.size());
        end else begin
            checks++;
            if (log_rwb[0] !== 1'b1 || log_addr[0] !== 8'h57) begin
                failures++;
                $display("[TB] FAIL refill_cmd: got rwb=%b addr=%h, required 1 57", log_rwb[0], log_addr[0]);
            end
        end
        checks++;
        if (rd !== 64'h0123_4567_89AB_CDEF) begin
            failures++;
            $display("[TB] FAIL refill_rdata: got %h, required 0123456789abcdef", rd);
        end
        @(negedge clk);
        checks++;
        if (overlap_errs != 0) begin
            failures++;
            $display("[TB] FAIL cmd_overlap: got %0d overlapping commands, required 0", overlap_errs);
        end
    endtask

    // Runs each scenario in order, then prints the summary line.
    initial begin
        $display("[TB] starting dram_wb_cache directed tests");
        test_reset();
        test_fill();
        test_hit();
        test_store_evict();
        test_wb_then_fill();
        test_store_load();
        test_back_to_back();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
